exu_wbck_ctrl: RTL and testbench



---
 rtl/exu_wbck_ctrl_pkg.sv | 19 +
 rtl/exu_wbck_ctrl_oitf.sv | 107 ++++++++++
 rtl/exu_wbck_ctrl.sv | 138 +++++++++++++
 tb/tb_exu_wbck_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_wbck_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exu_wbck_ctrl_pkg
// Shared constants for the EXU write-back path. These are the design-wide
// register-file defaults used by the write-back controller and its OITF.
//   DEF_XLEN         : datapath width
//   DEF_RFIDX_WIDTH  : register index width
//   RFREG_NUM        : number of architectural registers
//   OITF_ENTRY_W     : width of one OITF entry {rdwen, rdidx}
//   DEF_OITF_DEPTH   : default number of in-flight long-pipe instructions
// -----------------------------------------------------------------------------
package exu_wbck_ctrl_pkg;

    localparam int DEF_XLEN        = 32;
    localparam int DEF_RFIDX_WIDTH = 5;
    localparam int RFREG_NUM       = 1 << DEF_RFIDX_WIDTH;
    localparam int OITF_ENTRY_W    = DEF_RFIDX_WIDTH + 1;
    localparam int DEF_OITF_DEPTH  = 2;

endpackage

// File: rtl/exu_wbck_ctrl_oitf.sv
// -----------------------------------------------------------------------------
// exu_oitf
// Outstanding-instruction FIFO for long-pipe (LSU/MUL/DIV) instructions.
// Holds {rdwen, rdidx} per in-flight instruction, the read/write pointers
// (index plus wrap flag), full/empty status and a per-entry hazard match
// vector against the operands of the instruction being dispatched.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   alloc_i, alloc_*_i     : push a new entry at the write pointer
//   retire_i               : pop the entry at the read pointer
//   rs*/rd*_en_i, _idx_i   : operands of the dispatching instruction
//   full_o, empty_o        : occupancy status
//   wptr_idx_o, rptr_idx_o : pointer index bits (wptr index is the new itag)
//   ret_rdwen_o/rdidx_o    : contents of the oldest entry
//   match_o                : per-entry RAW/WAW hit
// -----------------------------------------------------------------------------
module exu_oitf
    import exu_wbck_ctrl_pkg::*;
#(
    parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH,
    parameter int DEPTH       = DEF_OITF_DEPTH,
    localparam int TAG_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_i,
    input  logic                   alloc_rdwen_i,
    input  logic [RFIDX_WIDTH-1:0] alloc_rdidx_i,
    input  logic                   retire_i,
    input  logic                   rs1_en_i,
    input  logic [RFIDX_WIDTH-1:0] rs1_idx_i,
    input  logic                   rs2_en_i,
    input  logic [RFIDX_WIDTH-1:0] rs2_idx_i,
    input  logic                   rd_en_i,
    input  logic [RFIDX_WIDTH-1:0] rd_idx_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [TAG_W-1:0]       wptr_idx_o,
    output logic [TAG_W-1:0]       rptr_idx_o,
    output logic                   ret_rdwen_o,
    output logic [RFIDX_WIDTH-1:0] ret_rdidx_o,
    output logic [DEPTH-1:0]       match_o
);

    // Pointers carry one extra MSB as a wrap flag so full and empty differ.
    logic [TAG_W:0] wptr_q, wptr_d;
    logic [TAG_W:0] rptr_q, rptr_d;

    logic [DEPTH-1:0]       ent_rdwen;
    logic [RFIDX_WIDTH-1:0] ent_rdidx [DEPTH];

    assign wptr_d = alloc_i  ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d = retire_i ? rptr_q + 1'b1 : rptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign wptr_idx_o = wptr_q[TAG_W-1:0];
    assign rptr_idx_o = rptr_q[TAG_W-1:0];
    assign empty_o    = (wptr_q == rptr_q);
    assign full_o     = (wptr_q[TAG_W-1:0] == rptr_q[TAG_W-1:0]) &&
                        (wptr_q[TAG_W] != rptr_q[TAG_W]);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic                   vld_q;
            logic                   rdwen_q;
            logic [RFIDX_WIDTH-1:0] rdidx_q;

            // Alloc and retire can never hit the same slot in one cycle:
            // that would require the FIFO to be both full and non-full.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q   <= 1'b0;
                    rdwen_q <= 1'b0;
                    rdidx_q <= '0;
                end else if (alloc_i && (wptr_q[TAG_W-1:0] == TAG_W'(gi))) begin
                    vld_q   <= 1'b1;
                    rdwen_q <= alloc_rdwen_i;
                    rdidx_q <= alloc_rdidx_i;
                end else if (retire_i && (rptr_q[TAG_W-1:0] == TAG_W'(gi))) begin
                    vld_q   <= 1'b0;
                end
            end

            assign ent_rdwen[gi] = rdwen_q;
            assign ent_rdidx[gi] = rdidx_q;

            // x0 is hard-wired, so a pending write to it is never a hazard.
            assign match_o[gi] = vld_q && rdwen_q && (rdidx_q != '0) &&
                                 ((rs1_en_i && (rs1_idx_i == rdidx_q)) ||
                                  (rs2_en_i && (rs2_idx_i == rdidx_q)) ||
                                  (rd_en_i  && (rd_idx_i  == rdidx_q)));
        end
    endgenerate

    assign ret_rdwen_o = ent_rdwen[rptr_q[TAG_W-1:0]];
    assign ret_rdidx_o = ent_rdidx[rptr_q[TAG_W-1:0]];

endmodule

// File: rtl/exu_wbck_ctrl.sv
// -----------------------------------------------------------------------------
// exu_wbck_ctrl
// Write-back controller owning the single register-file write port. Shares it
// between the single-cycle ALU and the long pipe (fixed priority to the long
// pipe), tracks long-pipe instructions in an OITF and raises dep_hazard so
// dispatch stalls on RAW/WAW conflicts with in-flight long-pipe results.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   disp_long_*                   : OITF allocation handshake, itag returned
//   disp_rs1/rs2/rd_en/_idx       : operands of the dispatching instruction
//   dep_hazard, oitf_empty        : dispatch stall / nothing in flight
//   alu_wbck_*                    : ALU result handshake
//   long_wbck_*                   : long-pipe result handshake (in tag order)
//   wbck_dest_ena/idx/data        : registered register-file write port
// -----------------------------------------------------------------------------
module exu_wbck_ctrl
    import exu_wbck_ctrl_pkg::*;
#(
    parameter int XLEN        = DEF_XLEN,
    parameter int RFIDX_WIDTH = DEF_RFIDX_WIDTH,
    parameter int OITF_DEPTH  = DEF_OITF_DEPTH,
    localparam int TAG_W      = $clog2(OITF_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   disp_long_valid,
    output logic                   disp_long_ready,
    input  logic                   disp_long_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_long_rdidx,
    output logic [TAG_W-1:0]       disp_long_itag,
    input  logic                   disp_rs1_en,
    input  logic                   disp_rs2_en,
    input  logic                   disp_rd_en,
    input  logic [RFIDX_WIDTH-1:0] disp_rs1_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_rs2_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_rd_idx,
    output logic                   dep_hazard,
    output logic                   oitf_empty,
    input  logic                   alu_wbck_valid,
    output logic                   alu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]        alu_wbck_data,
    input  logic                   long_wbck_valid,
    output logic                   long_wbck_ready,
    input  logic [TAG_W-1:0]       long_wbck_itag,
    input  logic [XLEN-1:0]        long_wbck_data,
    output logic                   wbck_dest_ena,
    output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
    output logic [XLEN-1:0]        wbck_dest_data
);

    logic                   oitf_full;
    logic                   alloc;
    logic                   retire;
    logic                   alu_fire;
    logic [TAG_W-1:0]       rptr_idx;
    logic                   ret_rdwen;
    logic [RFIDX_WIDTH-1:0] ret_rdidx;
    logic [OITF_DEPTH-1:0]  match_vec;

    logic                   ena_q, ena_d;
    logic [RFIDX_WIDTH-1:0] idx_q, idx_d;
    logic [XLEN-1:0]        data_q, data_d;

    // Ready depends only on current occupancy, never on a same-cycle retire.
    assign disp_long_ready = !oitf_full;
    assign alloc           = disp_long_valid && disp_long_ready;

    // Only the oldest tag may retire, which keeps long-pipe writes in order.
    assign long_wbck_ready = !oitf_empty && (long_wbck_itag == rptr_idx);
    assign retire          = long_wbck_valid && long_wbck_ready;

    assign alu_wbck_ready  = !retire;
    assign alu_fire        = alu_wbck_valid && alu_wbck_ready;

    assign dep_hazard      = |match_vec;

    exu_oitf #(
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .DEPTH       (OITF_DEPTH)
    ) u_oitf (
        .clk           (clk),
        .rst           (rst),
        .alloc_i       (alloc),
        .alloc_rdwen_i (disp_long_rdwen),
        .alloc_rdidx_i (disp_long_rdidx),
        .retire_i      (retire),
        .rs1_en_i      (disp_rs1_en),
        .rs1_idx_i     (disp_rs1_idx),
        .rs2_en_i      (disp_rs2_en),
        .rs2_idx_i     (disp_rs2_idx),
        .rd_en_i       (disp_rd_en),
        .rd_idx_i      (disp_rd_idx),
        .full_o        (oitf_full),
        .empty_o       (oitf_empty),
        .wptr_idx_o    (disp_long_itag),
        .rptr_idx_o    (rptr_idx),
        .ret_rdwen_o   (ret_rdwen),
        .ret_rdidx_o   (ret_rdidx),
        .match_o       (match_vec)
    );

    always_comb begin
        ena_d  = 1'b0;
        idx_d  = idx_q;
        data_d = data_q;
        if (retire) begin
            ena_d  = ret_rdwen;
            idx_d  = ret_rdidx;
            data_d = long_wbck_data;
        end else if (alu_fire) begin
            ena_d  = 1'b1;
            idx_d  = alu_wbck_idx;
            data_d = alu_wbck_data;
        end
        // x0 is read-only; suppress the write strobe but keep the pulse slot.
        if (idx_d == '0) begin
            ena_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_q  <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            ena_q  <= ena_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign wbck_dest_ena  = ena_q;
    assign wbck_dest_idx  = idx_q;
    assign wbck_dest_data = data_q;

endmodule

// File: tb/tb_exu_wbck_ctrl.sv
module tb_exu_wbck_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_long_valid;
    logic        disp_long_ready;
    logic        disp_long_rdwen;
    logic [4:0]  disp_long_rdidx;
    logic [0:0]  disp_long_itag;
    logic        disp_rs1_en, disp_rs2_en, disp_rd_en;
    logic [4:0]  disp_rs1_idx, disp_rs2_idx, disp_rd_idx;
    logic        dep_hazard;
    logic        oitf_empty;
    logic        alu_wbck_valid;
    logic        alu_wbck_ready;
    logic [4:0]  alu_wbck_idx;
    logic [31:0] alu_wbck_data;
    logic        long_wbck_valid;
    logic        long_wbck_ready;
    logic [0:0]  long_wbck_itag;
    logic [31:0] long_wbck_data;
    logic        wbck_dest_ena;
    logic [4:0]  wbck_dest_idx;
    logic [31:0] wbck_dest_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [32];

    always #5 clk = ~clk;

    // Register file fed by the write port, for read-back checks.
    always @(posedge clk) begin
        if (wbck_dest_ena) rf[wbck_dest_idx] <= wbck_dest_data;
    end

    exu_wbck_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .disp_long_valid (disp_long_valid),
        .disp_long_ready (disp_long_ready),
        .disp_long_rdwen (disp_long_rdwen),
        .disp_long_rdidx (disp_long_rdidx),
        .disp_long_itag  (disp_long_itag),
        .disp_rs1_en     (disp_rs1_en),
        .disp_rs2_en     (disp_rs2_en),
        .disp_rd_en      (disp_rd_en),
        .disp_rs1_idx    (disp_rs1_idx),
        .disp_rs2_idx    (disp_rs2_idx),
        .disp_rd_idx     (disp_rd_idx),
        .dep_hazard      (dep_hazard),
        .oitf_empty      (oitf_empty),
        .alu_wbck_valid  (alu_wbck_valid),
        .alu_wbck_ready  (alu_wbck_ready),
        .alu_wbck_idx    (alu_wbck_idx),
        .alu_wbck_data   (alu_wbck_data),
        .long_wbck_valid (long_wbck_valid),
        .long_wbck_ready (long_wbck_ready),
        .long_wbck_itag  (long_wbck_itag),
        .long_wbck_data  (long_wbck_data),
        .wbck_dest_ena   (wbck_dest_ena),
        .wbck_dest_idx   (wbck_dest_idx),
        .wbck_dest_data  (wbck_dest_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic ena, input logic [4:0] idx, input logic [31:0] data);
        chk({tag, ".ena"}, 32'(wbck_dest_ena), 32'(ena));
        if (ena) begin
            chk({tag, ".idx"},  32'(wbck_dest_idx), 32'(idx));
            chk({tag, ".data"}, wbck_dest_data, data);
        end
    endtask

    initial begin
        rst = 1'b1;
        disp_long_valid = 0; disp_long_rdwen = 0; disp_long_rdidx = 0;
        disp_rs1_en = 0; disp_rs2_en = 0; disp_rd_en = 0;
        disp_rs1_idx = 0; disp_rs2_idx = 0; disp_rd_idx = 0;
        alu_wbck_valid = 0; alu_wbck_idx = 0; alu_wbck_data = 0;
        long_wbck_valid = 0; long_wbck_itag = 0; long_wbck_data = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst.ena",   32'(wbck_dest_ena), 0);
        chk("rst.idx",   32'(wbck_dest_idx), 0);
        chk("rst.data",  wbck_dest_data, 0);
        chk("rst.empty", 32'(oitf_empty), 1);
        chk("rst.ready", 32'(disp_long_ready), 1);
        chk("rst.haz",   32'(dep_hazard), 0);
        chk("rst.itag",  32'(disp_long_itag), 0);
        rst = 1'b0;
        tick();
        $display("reset done");

        // ALU write x5 = DEADBEEF
        alu_wbck_valid = 1; alu_wbck_idx = 5; alu_wbck_data = 32'hDEADBEEF;
        #1 chk("alu1.ready", 32'(alu_wbck_ready), 1);
        tick();
        alu_wbck_valid = 0;
        chk_wr("alu1.wr", 1, 5, 32'hDEADBEEF);
        tick();
        chk("alu1.pulse", 32'(wbck_dest_ena), 0);
        chk("alu1.rf5", rf[5], 32'hDEADBEEF);
        $display("txn: alu write x5=deadbeef");

        // Allocate rd=7, RAW hazard on rs1=7
        disp_long_valid = 1; disp_long_rdwen = 1; disp_long_rdidx = 7;
        disp_rs1_en = 1; disp_rs1_idx = 7;
        #1;
        chk("alloc7.itag",  32'(disp_long_itag), 0);
        chk("alloc7.ready", 32'(disp_long_ready), 1);
        chk("alloc7.haz_same_cycle", 32'(dep_hazard), 0);
        tick();
        disp_long_valid = 0;
        chk("alloc7.haz_rs1", 32'(dep_hazard), 1);
        chk("alloc7.empty",   32'(oitf_empty), 0);
        disp_rs1_en = 0;
        #1 chk("alloc7.haz_none", 32'(dep_hazard), 0);
        disp_rs2_en = 1; disp_rs2_idx = 7;
        #1 chk("alloc7.haz_rs2", 32'(dep_hazard), 1);
        disp_rs2_en = 0; disp_rd_en = 1; disp_rd_idx = 7;
        #1 chk("alloc7.haz_rd", 32'(dep_hazard), 1);
        disp_rd_idx = 8;
        #1 chk("alloc7.haz_rd8", 32'(dep_hazard), 0);
        disp_rd_en = 0; disp_rs1_en = 1; disp_rs1_idx = 7;
        // Retire tag 0
        long_wbck_valid = 1; long_wbck_itag = 0; long_wbck_data = 32'h1234;
        #1;
        chk("ret7.lready", 32'(long_wbck_ready), 1);
        chk("ret7.aready", 32'(alu_wbck_ready), 0);
        chk("ret7.haz_still", 32'(dep_hazard), 1);
        tick();
        long_wbck_valid = 0;
        chk_wr("ret7.wr", 1, 7, 32'h1234);
        chk("ret7.haz_clear", 32'(dep_hazard), 0);
        chk("ret7.empty", 32'(oitf_empty), 1);
        disp_rs1_en = 0;
        $display("txn: long retire x7=1234");

        // ALU and long in same cycle: long wins
        disp_long_valid = 1; disp_long_rdwen = 1; disp_long_rdidx = 9;
        #1 chk("alloc9.itag", 32'(disp_long_itag), 1);
        tick();
        disp_long_valid = 0;
        long_wbck_valid = 1; long_wbck_itag = 1; long_wbck_data = 32'hAAAA;
        alu_wbck_valid = 1; alu_wbck_idx = 3; alu_wbck_data = 32'h5555;
        #1 chk("arb.aready0", 32'(alu_wbck_ready), 0);
        tick();
        long_wbck_valid = 0;
        chk_wr("arb.long", 1, 9, 32'hAAAA);
        #1 chk("arb.aready1", 32'(alu_wbck_ready), 1);
        tick();
        alu_wbck_valid = 0;
        chk_wr("arb.alu", 1, 3, 32'h5555);
        $display("txn: arbitration long x9 then alu x3");

        // Fill to full, out-of-order tag stalls, then in-order retire
        disp_long_valid = 1; disp_long_rdidx = 10;
        #1 chk("fill.itag0", 32'(disp_long_itag), 0);
        tick();
        disp_long_rdidx = 11;
        #1 chk("fill.itag1", 32'(disp_long_itag), 1);
        tick();
        chk("fill.ready0", 32'(disp_long_ready), 0);
        long_wbck_valid = 1; long_wbck_itag = 1; long_wbck_data = 32'hB1;
        #1;
        chk("fill.ooo_lready", 32'(long_wbck_ready), 0);
        chk("fill.ooo_aready", 32'(alu_wbck_ready), 1);
        long_wbck_itag = 0; long_wbck_data = 32'hB0;
        #1;
        chk("fill.lready0", 32'(long_wbck_ready), 1);
        chk("fill.ready_retire", 32'(disp_long_ready), 0);
        tick();
        disp_long_valid = 0;
        chk_wr("fill.wr10", 1, 10, 32'hB0);
        long_wbck_itag = 1; long_wbck_data = 32'hB1;
        #1 chk("fill.lready1", 32'(long_wbck_ready), 1);
        tick();
        long_wbck_valid = 0;
        chk_wr("fill.wr11", 1, 11, 32'hB1);
        chk("fill.empty", 32'(oitf_empty), 1);
        $display("txn: fill and in-order drain");

        // Steady-state allocate+retire across the wrap point
        disp_long_valid = 1; disp_long_rdidx = 12;
        tick();
        for (int i = 0; i < 10; i++) begin
            disp_long_rdidx = 5'(13 + i);
            long_wbck_valid = 1; long_wbck_itag = 1'(i % 2);
            long_wbck_data  = 32'h100 + 32'(i);
            #1;
            chk("wrap.itag",   32'(disp_long_itag), 32'((i + 1) % 2));
            chk("wrap.ready",  32'(disp_long_ready), 1);
            chk("wrap.lready", 32'(long_wbck_ready), 1);
            tick();
            chk_wr("wrap.wr", 1, 5'(12 + i), 32'h100 + 32'(i));
            chk("wrap.empty", 32'(oitf_empty), 0);
            $display("txn: wrap iter %0d retire x%0d", i, 12 + i);
        end
        disp_long_valid = 0;
        long_wbck_itag = 0; long_wbck_data = 32'h200;
        tick();
        long_wbck_valid = 0;
        chk_wr("wrap.last", 1, 22, 32'h200);
        chk("wrap.empty_end", 32'(oitf_empty), 1);

        // Writes to x0 never assert ena
        alu_wbck_valid = 1; alu_wbck_idx = 0; alu_wbck_data = 32'hFF;
        tick();
        alu_wbck_valid = 0;
        chk("x0.alu_ena", 32'(wbck_dest_ena), 0);
        disp_long_valid = 1; disp_long_rdwen = 1; disp_long_rdidx = 0;
        #1 chk("x0.itag", 32'(disp_long_itag), 1);
        tick();
        disp_long_valid = 0;
        disp_rs1_en = 1; disp_rs1_idx = 0;
        #1 chk("x0.haz", 32'(dep_hazard), 0);
        disp_rs1_en = 0;
        long_wbck_valid = 1; long_wbck_itag = 1; long_wbck_data = 32'hEE;
        tick();
        long_wbck_valid = 0;
        chk("x0.long_ena", 32'(wbck_dest_ena), 0);
        chk("x0.empty", 32'(oitf_empty), 1);
        $display("txn: x0 writes suppressed");

        // Reset mid-operation with two entries in flight and a write pending
        disp_long_valid = 1; disp_long_rdidx = 4;
        tick();
        disp_long_rdidx = 6;
        tick();
        disp_long_valid = 0;
        alu_wbck_valid = 1; alu_wbck_idx = 8; alu_wbck_data = 32'h77;
        tick();
        alu_wbck_valid = 0;
        disp_rs1_en = 1; disp_rs1_idx = 4;
        #1;
        chk("mid.ena", 32'(wbck_dest_ena), 1);
        chk("mid.ready", 32'(disp_long_ready), 0);
        chk("mid.haz", 32'(dep_hazard), 1);
        #1 rst = 1'b1;
        #1;
        chk("mrst.ena",   32'(wbck_dest_ena), 0);
        chk("mrst.idx",   32'(wbck_dest_idx), 0);
        chk("mrst.data",  wbck_dest_data, 0);
        chk("mrst.empty", 32'(oitf_empty), 1);
        chk("mrst.ready", 32'(disp_long_ready), 1);
        chk("mrst.haz",   32'(dep_hazard), 0);
        chk("mrst.itag",  32'(disp_long_itag), 0);
        $display("txn: reset with two in flight");
        tick();
        rst = 1'b0;
        disp_rs1_en = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
